// File: rtl/fnd_pkg.sv
// Shared segment constants, digit lookup and conversion-FSM states for the
// multiplexed seven-segment scan controller.
package fnd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    // Active-low {dp,g..a} pattern for a decimal digit; dp is left off.
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // Decimal digits needed to hold the largest w-bit unsigned value.
    function automatic int dec_digits(input int w);
        longint unsigned max_val;
        int              n;
        max_val = (64'd1 << w) - 64'd1;
        n       = 0;
        while (max_val != 64'd0) begin
            max_val = max_val / 64'd10;
            n++;
        end
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) binary to BCD converter, one bit per
// clock, with start/busy/done handshake and an input capture register.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [VALUE_W-1:0]      i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_commit,
    output logic [4*BCD_DIGITS-1:0] o_bcd
);

    localparam int ITER_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

    conv_state_t             r_state;
    logic [VALUE_W-1:0]      r_bin;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [ITER_W-1:0]       r_iter;
    logic                    r_busy;
    logic                    r_done;
    logic [4*BCD_DIGITS-1:0] w_bcd_adj;

    // Every digit of 5 or more gets +3 so the following shift carries correctly.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_bin   <= i_bin;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    if (r_iter == ITER_W'(VALUE_W - 1))
                        r_state <= ST_COMMIT;
                    else
                        r_iter <= r_iter + ITER_W'(1);
                end
                ST_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_commit = (r_state == ST_COMMIT);
    assign o_bcd    = r_bcd;

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode FND driver: BCD conversion behind a handshake, digit
// scan with PWM brightness, blinking, leading-zero blanking and overflow dashes.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    i_value,
    input  logic                  i_load,
    input  logic [NUM_DIGITS-1:0] i_dp,
    input  logic [NUM_DIGITS-1:0] i_blink,
    input  logic                  i_lzb,
    input  logic [3:0]            i_bright,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ovf,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd_data
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int SUB   = DIV / 16;
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int BCD_N = (dec_digits(VALUE_W) > NUM_DIGITS) ? dec_digits(VALUE_W) : NUM_DIGITS;

    logic [SUB_W-1:0]        r_sub;
    logic [3:0]              r_pwm;
    logic [IDX_W-1:0]        r_idx;
    logic [BLK_W-1:0]        r_blink_cnt;
    logic                    r_blink;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic                    r_ovf;
    logic [NUM_DIGITS-1:0]   r_com;
    logic [7:0]              r_data;

    logic                    w_sub_tick;
    logic                    w_commit;
    logic [4*BCD_N-1:0]      w_bcd;
    logic                    w_ovf;
    logic [NUM_DIGITS-1:0]   w_lead_zero;
    logic [3:0]              w_digit;
    logic [7:0]              w_seg;
    logic [7:0]              w_data;
    logic                    w_com_on;
    logic [NUM_DIGITS-1:0]   w_com;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .BCD_DIGITS (BCD_N)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_load),
        .i_bin    (i_value),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_commit (w_commit),
        .o_bcd    (w_bcd)
    );

    assign w_sub_tick = (r_sub == SUB_W'(SUB - 1));

    // Sub-slot divider drives PWM phase; a full PWM cycle is one digit slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sub       <= '0;
            r_pwm       <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_sub_tick) begin
            r_sub <= '0;
            r_pwm <= r_pwm + 4'd1;
            if (r_pwm == 4'd15) begin
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
                if (r_blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLK_W'(1);
                end
            end
        end else begin
            r_sub <= r_sub + SUB_W'(1);
        end
    end

    always_comb begin
        w_ovf = 1'b0;
        for (int i = NUM_DIGITS; i < BCD_N; i++)
            w_ovf = w_ovf | (|w_bcd[4*i +: 4]);
    end

    // The display only changes on commit, so a half-shifted value is never shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_commit) begin
            r_disp <= w_bcd[4*NUM_DIGITS-1:0];
            r_ovf  <= w_ovf;
        end
    end

    always_comb begin
        logic all_zero;
        all_zero    = 1'b1;
        w_lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero       = all_zero & (r_disp[4*i +: 4] == 4'd0);
            w_lead_zero[i] = all_zero;
        end
    end

    always_comb begin
        w_digit = r_disp[4*r_idx +: 4];
        if (r_ovf)
            w_seg = SEG_DASH;
        else if (i_lzb && (r_idx != '0) && w_lead_zero[r_idx])
            w_seg = SEG_BLANK;
        else
            w_seg = seg_decode(w_digit);
        w_data   = {w_seg[7] & ~i_dp[r_idx], w_seg[6:0]};
        w_com_on = (r_pwm <= i_bright) && !(i_blink[r_idx] && r_blink);
        w_com    = '1;
        if (w_com_on)
            w_com[r_idx] = 1'b0;
    end

    // Registering com and data together keeps segments and enables aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_com  <= '1;
            r_data <= SEG_BLANK;
        end else begin
            r_com  <= w_com;
            r_data <= w_data;
        end
    end

    assign o_ovf    = r_ovf;
    assign fnd_com  = r_com;
    assign fnd_data = r_data;

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Parametrised multiplexed seven-segment display driver for NUM_DIGITS common-anode digits. It converts a binary value to BCD with a multi-cycle shift-add converter behind a load/busy/done handshake. It then scans the digits at a fixed refresh rate, with per-digit decimal points, leading-zero blanking, per-digit blinking, 16-level PWM brightness and an overflow indication. It sits between the counter/sensor datapaths (stopwatch, DHT11, SR04) and the board FND pins.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- SCAN_HZ, 1000, digit-advance rate; CLK_HZ/SCAN_HZ must be a multiple of 16
- NUM_DIGITS, 4, number of digits, legal range 1..8
- VALUE_W, 14, width of binary input value
- BLINK_TICKS, 250, scan ticks per blink half-period
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- i_value  input  VALUE_W  unsigned binary value to display
- i_load  input  1  request conversion of i_value (sampled when o_busy=0)
- i_dp  input  NUM_DIGITS  decimal point enable per digit, bit 0 = rightmost
- i_blink  input  NUM_DIGITS  blink enable per digit
- i_lzb  input  1  leading-zero blanking enable
- i_bright  input  4  brightness, 0 = 1/16 duty, 15 = full
- o_busy  output  1  conversion in progress
- o_done  output  1  one-cycle pulse when the new value is committed to the display
- o_ovf  output  1  last committed value exceeded 10^NUM_DIGITS-1
- fnd_com  output  NUM_DIGITS  digit enables, active-low
- fnd_data  output  8  segments {dp,g..a}, active-low

## Operation
- Dividers:
  - Sub-slot counter pulses every DIV/16 clocks, where DIV = CLK_HZ/SCAN_HZ.
  - 4-bit pwm_phase increments on each sub-slot pulse.
  - Digit index advances when pwm_phase wraps 15→0 and wraps from NUM_DIGITS-1 to 0.
  - blink_phase toggles every BLINK_TICKS digit advances.
- Conversion FSM, states IDLE → SHIFT → COMMIT → IDLE:
  - IDLE: i_load=1 captures i_value and sets o_busy; next state SHIFT.
  - SHIFT: one double-dabble iteration per clock, VALUE_W clocks in total.
  - COMMIT: writes the display register atomically, pulses o_done, updates o_ovf, clears o_busy.
- Overflow: if the BCD result has any nonzero digit at position ≥ NUM_DIGITS, every digit shows a dash (8'hBF with dp honoured) and o_ovf=1. Otherwise o_ovf=0.
- Segment encoding for digit d: 0-9 use the standard hex table (C0,F9,A4,B0,99,92,82,F8,80,90). Blank = 8'hFF.
- Leading-zero blanking: with i_lzb=1, digits above the most significant nonzero digit are blank. Digit 0 is never blanked. i_lzb is ignored in overflow.
- dp: fnd_data[7]=0 when i_dp[idx]=1, including on blanked digits.
- Blink: when i_blink[idx]=1 and blink_phase=1, fnd_com stays all-ones for that slot.
- Brightness: the selected digit's com is asserted only while pwm_phase ≤ i_bright. Otherwise fnd_com is all-ones.
- i_dp, i_blink, i_lzb and i_bright act live, not latched.

## Timing
- Reset values:
  - fnd_com all-ones, fnd_data 8'hFF
  - o_busy=0, o_done=0, o_ovf=0
  - display register zero, all counters and phases zero, FSM in IDLE
- Conversion latency: i_load sampled at edge N gives o_busy=1 from N+1 and o_done at N+VALUE_W+2. o_busy falls in the same cycle o_done is high.
- i_load while o_busy=1 is ignored; no queueing.
- A load in the same cycle as COMMIT is ignored. A load in the following cycle is accepted.
- The display never shows a partially converted value. The old value is held until COMMIT.
- fnd_com and fnd_data are registered: one clock after the index or pwm_phase change. Both update in the same cycle (no ghosting skew).
- Reset mid-conversion aborts it: o_busy=0, no o_done pulse, display is zero.

## Structure
- Package fnd_pkg holds:
  - segment constants SEG_BLANK=8'hFF, SEG_DASH=8'hBF
  - the 10-entry digit segment table as a function
  - the FSM state enum
- Sub-module bin2bcd_seq (parametrised VALUE_W and output BCD digit count) holds the shift-add core, its start/busy/done handshake and the capture register.
- The top holds the dividers, scan, blink, PWM, overflow detection and output registers.

## Test plan
Bench parameters: CLK_HZ=1600, SCAN_HZ=100, DIV=16, BLINK_TICKS=4.
- Reset then no load: every slot shows fnd_data=8'hC0. fnd_com cycles 1110,1101,1011,0111 with each digit held 16 clocks.
- Load 1234, i_bright=15: o_done exactly 16 clocks after the load edge. Digits 3..0 show F9,A4,B0,99 (1,2,3,4).
- Load 7, i_lzb=1, i_dp=4'b0100: digit 0 shows F8. Digits 1 and 3 show FF. Digit 2 shows 7F.
- Load 12345 with NUM_DIGITS=4: o_ovf=1 and all digits show BF. A subsequent load of 9999 clears o_ovf.
- i_bright=3: each digit's com is low for 4 of its 16 clocks. i_blink=4'b0001: digit 0 com stays high for 4 of every 8 scan ticks.
- Load 999, a second load at +3 clocks, then rst=0 at +8 clocks: the second load is ignored, there is no o_done pulse, all outputs are at reset values, and after release the display shows 0000.
